// File: rtl/fpnew_add_special_case_if.sv
// -----------------------------------------------------------------------------
// fpnew_pkg_versacore / fpnew_add_special_case_if
//
// Purpose:
//   Format helpers and the operand classification record, followed by the
//   bundle that carries one add/sub special-case operation in and one
//   resolved result out.
//
// Interface signals:
//   in_valid_i / in_ready_o   input handshake
//   operands_i [1:0]          operand a = [0], b = [1]
//   info_i     [1:0]          classification of operands_i (same cycle)
//   op_sub_i                  1 = a - b
//   rnd_mode_i                RISC-V rounding mode
//   tag_i                     opaque tag travelling with the operation
//   out_valid_o / out_ready_i output handshake
//   is_special_o, result_o, status_nv_o, tag_o   resolved result
//
// Handshake rule (both directions): a transfer happens on a rising clock edge
// where valid and ready are both 1. A source that raises valid keeps valid and
// its payload stable until that transfer; ready may change freely and never
// waits on valid.
//
// Modports: master = producer of operations / consumer of results,
//           slave  = the special-case block.
// -----------------------------------------------------------------------------
package fpnew_pkg_versacore;

   typedef enum logic [2:0] {
      FP32    = 3'd0,
      FP64    = 3'd1,
      FP16    = 3'd2,
      FP8     = 3'd3,
      FP16ALT = 3'd4
   } fp_format_e;

   function automatic int unsigned fp_width(fp_format_e fmt);
      case (fmt)
         FP32:    return 32;
         FP64:    return 64;
         FP16:    return 16;
         FP8:     return 8;
         default: return 16;
      endcase
   endfunction

   function automatic int unsigned exp_bits(fp_format_e fmt);
      case (fmt)
         FP32:    return 8;
         FP64:    return 11;
         FP16:    return 5;
         FP8:     return 5;
         default: return 8;
      endcase
   endfunction

   typedef struct packed {
      logic is_normal;
      logic is_subnormal;
      logic is_zero;
      logic is_inf;
      logic is_nan;
      logic is_signalling;
      logic is_quiet;
      logic is_boxed;
   } fp_info_t;

endpackage

interface fpnew_add_special_case_if #(
   parameter int unsigned WIDTH    = 32,
   parameter int unsigned TagWidth = 4
);
   logic                                 in_valid_i;
   logic                                 in_ready_o;
   logic [1:0][WIDTH-1:0]                operands_i;
   fpnew_pkg_versacore::fp_info_t [1:0]  info_i;
   logic                                 op_sub_i;
   logic [2:0]                           rnd_mode_i;
   logic [TagWidth-1:0]                  tag_i;
   logic                                 out_valid_o;
   logic                                 out_ready_i;
   logic                                 is_special_o;
   logic [WIDTH-1:0]                     result_o;
   logic                                 status_nv_o;
   logic [TagWidth-1:0]                  tag_o;

   modport master (
      output in_valid_i, operands_i, info_i, op_sub_i, rnd_mode_i, tag_i, out_ready_i,
      input  in_ready_o, out_valid_o, is_special_o, result_o, status_nv_o, tag_o
   );

   modport slave (
      input  in_valid_i, operands_i, info_i, op_sub_i, rnd_mode_i, tag_i, out_ready_i,
      output in_ready_o, out_valid_o, is_special_o, result_o, status_nv_o, tag_o
   );
endinterface

// File: rtl/fpnew_add_special_case.sv
// -----------------------------------------------------------------------------
// fpnew_add_special_case
//
// Purpose:
//   Resolves IEEE-754 special cases (NaN, Inf, Inf-Inf, zero operands) of an
//   add/sub from the operand classification and flags results that bypass the
//   main adder. The resolved result travels through an elastic valid/ready
//   pipeline of NumPipeRegs stages (0 = purely combinational).
//
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   flush_i         drops every in-flight operation on the next edge
//   io (slave)      operation in / resolved result out (fpnew_add_special_case_if)
//   busy_o          some pipeline stage holds a valid operation
//   cnt_clear_i     zero the event counters
//   cnt_nan_o       canonical-NaN results delivered
//   cnt_nv_o        invalid-flagged results delivered
//
// Optional feature: define FPNEW_SPECIAL_CNT_EN to build the saturating
// delivery counters; without it the counter outputs are tied to zero.
// -----------------------------------------------------------------------------
module fpnew_add_special_case #(
   parameter fpnew_pkg_versacore::fp_format_e FpFormat = fpnew_pkg_versacore::fp_format_e'(0),
   parameter int unsigned WIDTH       = fpnew_pkg_versacore::fp_width(FpFormat),
   parameter int unsigned NumPipeRegs = 1,
   parameter int unsigned TagWidth    = 4
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic                         flush_i,
   fpnew_add_special_case_if.slave      io,
   output logic                         busy_o,
   input  logic                         cnt_clear_i,
   output logic [31:0]                  cnt_nan_o,
   output logic [31:0]                  cnt_nv_o
);

   localparam int unsigned     ExpBits = fpnew_pkg_versacore::exp_bits(FpFormat);
   localparam int unsigned     ManBits = WIDTH - 1 - ExpBits;
   localparam logic [WIDTH-1:0] QNAN   = {1'b0, {ExpBits{1'b1}}, 1'b1, {(ManBits-1){1'b0}}};
   localparam logic [2:0]       RDN    = 3'b010;

   typedef struct packed {
      logic                special;
      logic [WIDTH-1:0]    result;
      logic                nv;
      logic [TagWidth-1:0] tag;
   } stage_t;

   // ---------------------------------------------------------------- case logic
   logic [WIDTH-1:0] op_a, op_b;
   logic             sign_a, sign_b_eff;
   logic             a_nan, b_nan;
   logic             zero_sign;
   logic             sp_special, sp_nv;
   logic [WIDTH-1:0] sp_result;
   stage_t           in_data;

   assign op_a       = io.operands_i[0];
   assign op_b       = io.operands_i[1];
   assign sign_a     = op_a[WIDTH-1];
   assign sign_b_eff = op_b[WIDTH-1] ^ io.op_sub_i;
   // A value that is not properly NaN-boxed is treated as NaN.
   assign a_nan      = io.info_i[0].is_nan | ~io.info_i[0].is_boxed;
   assign b_nan      = io.info_i[1].is_nan | ~io.info_i[1].is_boxed;
   // Exact cancellation of zeros is -0 only when rounding down.
   assign zero_sign  = (sign_a == sign_b_eff) ? sign_a : (io.rnd_mode_i == RDN);

   always_comb begin
      sp_special = 1'b1;
      sp_result  = '0;
      sp_nv      = 1'b0;
      if (a_nan || b_nan) begin
         sp_result = QNAN;
         sp_nv     = io.info_i[0].is_signalling | io.info_i[1].is_signalling;
      end else if (io.info_i[0].is_inf && io.info_i[1].is_inf && (sign_a != sign_b_eff)) begin
         sp_result = QNAN;
         sp_nv     = 1'b1;
      end else if (io.info_i[0].is_inf) begin
         sp_result = op_a;
      end else if (io.info_i[1].is_inf) begin
         sp_result = {sign_b_eff, op_b[WIDTH-2:0]};
      end else if (io.info_i[0].is_zero && io.info_i[1].is_zero) begin
         sp_result = {zero_sign, {(WIDTH-1){1'b0}}};
      end else if (io.info_i[0].is_zero) begin
         sp_result = {sign_b_eff, op_b[WIDTH-2:0]};
      end else if (io.info_i[1].is_zero) begin
         sp_result = op_a;
      end else begin
         sp_special = 1'b0;
      end
   end

   assign in_data = {sp_special, sp_result, sp_nv, io.tag_i};

   logic unused_info;
   assign unused_info = ^{io.info_i[0].is_normal, io.info_i[0].is_subnormal, io.info_i[0].is_quiet,
                          io.info_i[1].is_normal, io.info_i[1].is_subnormal, io.info_i[1].is_quiet};

   // ---------------------------------------------------------------- pipeline
   logic   out_valid;
   stage_t out_data;

   if (NumPipeRegs == 0) begin : g_comb
      assign io.in_ready_o = io.out_ready_i && !flush_i;
      assign out_valid     = io.in_valid_i && !flush_i;
      assign out_data      = in_data;
      assign busy_o        = 1'b0;
   end else begin : g_pipe
      localparam int unsigned N = NumPipeRegs;

      logic   [N-1:0] valid_q, valid_d, ready, stage_in_valid;
      stage_t [N-1:0] data_q, data_d, stage_in_data;

      assign stage_in_valid[0] = io.in_valid_i;
      assign stage_in_data[0]  = in_data;

      for (genvar i = 0; i < N; i++) begin : g_stage
         if (i > 0) begin : g_link
            assign stage_in_valid[i] = valid_q[i-1];
            assign stage_in_data[i]  = data_q[i-1];
         end
         // Stage i can load when it, or any stage after it, has a hole, or
         // the output is being drained.
         assign ready[i]   = io.out_ready_i || !(&valid_q[N-1:i]);
         assign valid_d[i] = flush_i  ? 1'b0 :
                             ready[i] ? stage_in_valid[i] : valid_q[i];
         assign data_d[i]  = (ready[i] && stage_in_valid[i]) ? stage_in_data[i] : data_q[i];
      end

      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            valid_q <= '0;
            data_q  <= '0;
         end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
         end
      end

      assign io.in_ready_o = ready[0] && !flush_i;
      assign out_valid     = valid_q[N-1];
      assign out_data      = data_q[N-1];
      assign busy_o        = |valid_q;
   end

   // Payload is masked while no result is presented, so idle outputs read zero.
   assign io.out_valid_o  = out_valid;
   assign io.is_special_o = out_valid && out_data.special;
   assign io.result_o     = (out_valid && out_data.special) ? out_data.result : '0;
   assign io.status_nv_o  = out_valid && out_data.nv;
   assign io.tag_o        = out_valid ? out_data.tag : '0;

   // ---------------------------------------------------------------- counters
`ifdef FPNEW_SPECIAL_CNT_EN
   logic        out_fire;
   logic [31:0] cnt_nan_q, cnt_nan_d, cnt_nv_q, cnt_nv_d;

   assign out_fire = io.out_valid_o && io.out_ready_i && !flush_i;

   always_comb begin
      cnt_nan_d = cnt_nan_q;
      cnt_nv_d  = cnt_nv_q;
      if (cnt_clear_i) begin
         cnt_nan_d = '0;
         cnt_nv_d  = '0;
      end else if (out_fire) begin
         if (io.is_special_o && (io.result_o == QNAN) && (cnt_nan_q != 32'hFFFF_FFFF))
            cnt_nan_d = cnt_nan_q + 32'd1;
         if (io.status_nv_o && (cnt_nv_q != 32'hFFFF_FFFF))
            cnt_nv_d = cnt_nv_q + 32'd1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_nan_q <= '0;
         cnt_nv_q  <= '0;
      end else begin
         cnt_nan_q <= cnt_nan_d;
         cnt_nv_q  <= cnt_nv_d;
      end
   end

   assign cnt_nan_o = cnt_nan_q;
   assign cnt_nv_o  = cnt_nv_q;
`else
   logic unused_cnt_clear;
   assign unused_cnt_clear = cnt_clear_i;
   assign cnt_nan_o        = '0;
   assign cnt_nv_o         = '0;
`endif

endmodule
